// File: rtl/btb_pkg.sv
// btb_pkg -- shared constants, entry type and PC field helpers for the BTB.
//   INDEX_W : index width, index taken from pc[INDEX_W+1:2]
//   TAG_W   : tag width, tag taken from pc[INDEX_W+TAG_W+1:INDEX_W+2]
//   TGT_W   : stored target width, target[TGT_W+1:2]
//   btb_entry_t : {tag, target} as held in btb_array
package btb_pkg;

   localparam int INDEX_W = 7;
   localparam int TAG_W   = 6;
   localparam int TGT_W   = 14;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [TGT_W-1:0] target;
   } btb_entry_t;

   function automatic logic [INDEX_W-1:0] pc_index(input logic [31:0] pc);
      return pc[INDEX_W+1:2];
   endfunction

   function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
      return pc[INDEX_W+TAG_W+1:INDEX_W+2];
   endfunction

   function automatic btb_entry_t make_entry(input logic [31:0] pc,
                                             input logic [31:0] target);
      btb_entry_t e;
      e.tag    = pc_tag(pc);
      e.target = target[TGT_W+1:2];
      return e;
   endfunction

endpackage

// File: rtl/btb_array.sv
// btb_array -- simple dual-port storage for BTB entries, inferred block RAM.
//   wr_clk/wr_en/wr_addr/wr_data : write port
//   rd_clk/rd_en/rd_addr         : read port, registered read data on rd_data
// Contents are never initialised; validity is tracked by the controller.
// A read and write to the same address on the same edge returns old data.
module btb_array #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 20
) (
   input  logic              wr_clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_clk,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [1<<ADDR_W];
   logic [DATA_W-1:0] rd_data_reg;

   always_ff @(posedge wr_clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge rd_clk) begin
      if (rd_en) begin
         rd_data_reg <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_reg;

endmodule

// File: rtl/btb_ctrl.sv
// btb_ctrl -- branch target buffer controller.
//   clk, rst_n           : clock, asynchronous active-low reset
//   lk_valid, lk_pc      : lookup request
//   rsp_valid/hit/target : lookup response, one cycle after the request
//   upd_valid, upd_inval : update / invalidate request, upd_pc, upd_target
//   flush                : clear every valid bit
//   hit_cnt, miss_cnt    : saturating response counters
// Updates pass through one write-stage register before reaching the array,
// so array write timing never depends on lookup traffic. Valid bits live
// here and take effect immediately; the entry data is forwarded from the
// update port (same cycle) or from the write stage (one cycle later) until
// the array read can see it.
module btb_ctrl #(
   parameter int INDEX_W = btb_pkg::INDEX_W,
   parameter int TAG_W   = btb_pkg::TAG_W,
   parameter int TGT_W   = btb_pkg::TGT_W
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        lk_valid,
   input  logic [31:0] lk_pc,
   output logic        rsp_valid,
   output logic        rsp_hit,
   output logic [31:0] rsp_target,
   input  logic        upd_valid,
   input  logic        upd_inval,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target,
   input  logic        flush,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
);

   import btb_pkg::*;

   localparam int DEPTH   = 1 << INDEX_W;
   localparam int ENTRY_W = TAG_W + TGT_W;

   logic [INDEX_W-1:0] lk_idx;
   logic [INDEX_W-1:0] upd_idx;
   btb_entry_t         upd_entry;
   logic [DEPTH-1:0]   valid_reg;

   // write stage
   logic               wr_en_reg;
   logic [INDEX_W-1:0] wr_idx_reg;
   btb_entry_t         wr_entry_reg;

   // lookup-side forwarding decision, computed in the request cycle
   logic               lk_hit_valid;
   logic               lk_fwd_sel;
   btb_entry_t         lk_fwd_entry;

   // response stage
   logic               rsp_valid_reg;
   logic [31:0]        lk_pc_reg;
   logic               hit_valid_reg;
   logic               fwd_sel_reg;
   btb_entry_t         fwd_entry_reg;
   logic [ENTRY_W-1:0] rd_data;
   btb_entry_t         rd_entry;
   btb_entry_t         resp_entry;

   logic [31:0]        hit_cnt_reg;
   logic [31:0]        miss_cnt_reg;

   // PC bits outside index/tag and target bits outside the stored field
   logic unused_bits;
   assign unused_bits = ^{upd_pc[31:INDEX_W+TAG_W+2], upd_pc[1:0],
                          upd_target[31:TGT_W+2], upd_target[1:0]};

   assign lk_idx    = pc_index(lk_pc);
   assign upd_idx   = pc_index(upd_pc);
   assign upd_entry = make_entry(upd_pc, upd_target);

   // Per-entry valid flops: flush wins over any concurrent update.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_reg[gi] <= 1'b0;
         end else if (flush) begin
            valid_reg[gi] <= 1'b0;
         end else if (upd_valid && (upd_idx == INDEX_W'(gi))) begin
            valid_reg[gi] <= !upd_inval;
         end
      end
   end

   // Write stage: only real (non-invalidate, non-flushed) updates reach the array.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en_reg    <= 1'b0;
         wr_idx_reg   <= '0;
         wr_entry_reg <= '0;
      end else begin
         wr_en_reg    <= upd_valid && !upd_inval && !flush;
         wr_idx_reg   <= upd_idx;
         wr_entry_reg <= upd_entry;
      end
   end

   btb_array #(
      .ADDR_W (INDEX_W),
      .DATA_W (ENTRY_W)
   ) u_array (
      .wr_clk  (clk),
      .wr_en   (wr_en_reg),
      .wr_addr (wr_idx_reg),
      .wr_data (wr_entry_reg),
      .rd_clk  (clk),
      .rd_en   (lk_valid),
      .rd_addr (lk_idx),
      .rd_data (rd_data)
   );

   assign rd_entry = rd_data;

   // The array read issued this cycle cannot see a same-cycle update, nor
   // the write-stage entry being written on the same edge, so both are
   // captured here and override the array data in the response cycle.
   always_comb begin
      lk_fwd_sel   = 1'b0;
      lk_fwd_entry = upd_entry;
      lk_hit_valid = valid_reg[lk_idx];
      if (upd_valid && (upd_idx == lk_idx)) begin
         lk_fwd_sel   = 1'b1;
         lk_fwd_entry = upd_entry;
         lk_hit_valid = !upd_inval;
      end else if (wr_en_reg && (wr_idx_reg == lk_idx)) begin
         lk_fwd_sel   = 1'b1;
         lk_fwd_entry = wr_entry_reg;
      end
      if (flush) begin
         lk_hit_valid = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_reg <= 1'b0;
         lk_pc_reg     <= '0;
         hit_valid_reg <= 1'b0;
         fwd_sel_reg   <= 1'b0;
         fwd_entry_reg <= '0;
      end else begin
         rsp_valid_reg <= lk_valid;
         if (lk_valid) begin
            lk_pc_reg     <= lk_pc;
            hit_valid_reg <= lk_hit_valid;
            fwd_sel_reg   <= lk_fwd_sel;
            fwd_entry_reg <= lk_fwd_entry;
         end
      end
   end

   assign resp_entry = fwd_sel_reg ? fwd_entry_reg : rd_entry;
   assign rsp_valid  = rsp_valid_reg;
   assign rsp_hit    = rsp_valid_reg && hit_valid_reg &&
                       (resp_entry.tag == pc_tag(lk_pc_reg));

   // Outputs read zero when no response is presented (including after reset).
   always_comb begin
      rsp_target = '0;
      if (rsp_valid_reg) begin
         if (rsp_hit) begin
            rsp_target = {lk_pc_reg[31:TGT_W+2], resp_entry.target, 2'b00};
         end else begin
            rsp_target = lk_pc_reg + 32'd4;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_reg  <= '0;
         miss_cnt_reg <= '0;
      end else if (rsp_valid_reg) begin
         if (rsp_hit) begin
            if (hit_cnt_reg != 32'hFFFF_FFFF) begin
               hit_cnt_reg <= hit_cnt_reg + 32'd1;
            end
         end else begin
            if (miss_cnt_reg != 32'hFFFF_FFFF) begin
               miss_cnt_reg <= miss_cnt_reg + 32'd1;
            end
         end
      end
   end

   assign hit_cnt  = hit_cnt_reg;
   assign miss_cnt = miss_cnt_reg;

endmodule

// File: tb/tb_btb_ctrl.sv
// tb_btb_ctrl -- directed vector bench for btb_ctrl.
// Each table row drives one cycle of lookup/update/flush and checks the
// response that appears in the following cycle; counters are checked
// against a running tally of the expected responses.
module tb_btb_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        lk_valid;
   logic [31:0] lk_pc;
   logic        rsp_valid;
   logic        rsp_hit;
   logic [31:0] rsp_target;
   logic        upd_valid;
   logic        upd_inval;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        flush;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   int checks = 0;
   int errors = 0;
   int exp_hits = 0;
   int exp_misses = 0;

   always #5 clk = ~clk;

   btb_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .lk_valid   (lk_valid),
      .lk_pc      (lk_pc),
      .rsp_valid  (rsp_valid),
      .rsp_hit    (rsp_hit),
      .rsp_target (rsp_target),
      .upd_valid  (upd_valid),
      .upd_inval  (upd_inval),
      .upd_pc     (upd_pc),
      .upd_target (upd_target),
      .flush      (flush),
      .hit_cnt    (hit_cnt),
      .miss_cnt   (miss_cnt)
   );

   typedef struct {
      logic        lk_valid;
      logic [31:0] lk_pc;
      logic        upd_valid;
      logic        upd_inval;
      logic [31:0] upd_pc;
      logic [31:0] upd_target;
      logic        flush;
      logic        exp_valid;
      logic        exp_hit;
      logic [31:0] exp_target;
   } vec_t;

   localparam int NVEC = 18;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      lk_valid   = 1'b0;
      lk_pc      = '0;
      upd_valid  = 1'b0;
      upd_inval  = 1'b0;
      upd_pc     = '0;
      upd_target = '0;
      flush      = 1'b0;
   endtask

   initial begin
      // lk_v  lk_pc          upd_v inval upd_pc         upd_target     flush exp_v hit exp_target
      vecs[0]  = '{1'b1, 32'h0000_1000, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_1004};
      vecs[1]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_1000, 32'h0000_2040, 1'b0, 1'b0, 1'b0, 32'h0};
      // next cycle after update: entry still in the write stage
      vecs[2]  = '{1'b1, 32'h0000_1000, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_2040};
      // now read from the array itself
      vecs[3]  = '{1'b1, 32'h0000_1000, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_2040};
      // 0x5000: index 0 like 0x1000, pc[14] differs so the tag differs
      vecs[4]  = '{1'b1, 32'h0000_5000, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_5004};
      // 0x9000: differs from 0x1000 only in pc[15], outside the tag -> aliases
      vecs[5]  = '{1'b1, 32'h0000_9000, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_2040};
      // same-cycle update and lookup
      vecs[6]  = '{1'b1, 32'h0000_1000, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_3080, 1'b0, 1'b1, 1'b1, 32'h0000_3080};
      vecs[7]  = '{1'b1, 32'h0000_1000, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_3080};
      // same-cycle invalidate and lookup
      vecs[8]  = '{1'b1, 32'h0000_1000, 1'b1, 1'b1, 32'h0000_1000, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_1004};
      vecs[9]  = '{1'b1, 32'h0000_1000, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_1004};
      // index 5 entry
      vecs[10] = '{1'b1, 32'h0000_0014, 1'b1, 1'b0, 32'h0000_0014, 32'h0000_0100, 1'b0, 1'b1, 1'b1, 32'h0000_0100};
      vecs[11] = '{1'b1, 32'h0000_0014, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_2040, 1'b0, 1'b1, 1'b1, 32'h0000_0100};
      // flush with concurrent update to index 5 and lookup of index 5
      vecs[12] = '{1'b1, 32'h0000_0014, 1'b1, 1'b0, 32'h0000_0014, 32'h0000_0200, 1'b1, 1'b1, 1'b0, 32'h0000_0018};
      vecs[13] = '{1'b1, 32'h0000_0014, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_0018};
      vecs[14] = '{1'b1, 32'h0000_1000, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_1004};
      // upper PC bits come from the lookup PC
      vecs[15] = '{1'b1, 32'hABCD_1000, 1'b1, 1'b0, 32'hABCD_1000, 32'h0000_2040, 1'b0, 1'b1, 1'b1, 32'hABCD_2040};
      // last index, miss target wraps
      vecs[16] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_0000};
      vecs[17] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 32'h0};

      idle_inputs();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("reset_rsp_hit", {31'd0, rsp_hit}, 32'd0);
      check("reset_rsp_target", rsp_target, 32'd0);
      check("reset_hit_cnt", hit_cnt, 32'd0);
      check("reset_miss_cnt", miss_cnt, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         lk_valid   = vecs[i].lk_valid;
         lk_pc      = vecs[i].lk_pc;
         upd_valid  = vecs[i].upd_valid;
         upd_inval  = vecs[i].upd_inval;
         upd_pc     = vecs[i].upd_pc;
         upd_target = vecs[i].upd_target;
         flush      = vecs[i].flush;
         step();
         $display("vec %0d lk=%0b pc=%h upd=%0b inv=%0b flush=%0b -> valid=%0b hit=%0b tgt=%h hits=%0d misses=%0d",
                  i, vecs[i].lk_valid, vecs[i].lk_pc, vecs[i].upd_valid, vecs[i].upd_inval,
                  vecs[i].flush, rsp_valid, rsp_hit, rsp_target, hit_cnt, miss_cnt);
         check($sformatf("vec%0d_rsp_valid", i), {31'd0, rsp_valid}, {31'd0, vecs[i].exp_valid});
         check($sformatf("vec%0d_rsp_hit", i), {31'd0, rsp_hit}, {31'd0, vecs[i].exp_hit});
         check($sformatf("vec%0d_rsp_target", i), rsp_target, vecs[i].exp_target);
         // counters lag one cycle: they include responses of earlier rows only
         check($sformatf("vec%0d_hit_cnt", i), hit_cnt, 32'(exp_hits));
         check($sformatf("vec%0d_miss_cnt", i), miss_cnt, 32'(exp_misses));
         if (vecs[i].exp_valid) begin
            if (vecs[i].exp_hit) exp_hits++;
            else exp_misses++;
         end
      end
      idle_inputs();
      step();
      check("final_hit_cnt", hit_cnt, 32'(exp_hits));
      check("final_miss_cnt", miss_cnt, 32'(exp_misses));

      // reset asserted while a lookup is in flight
      lk_valid = 1'b1;
      lk_pc    = 32'hABCD_1000;
      step();
      $display("pre-reset lookup -> valid=%0b hit=%0b tgt=%h", rsp_valid, rsp_hit, rsp_target);
      check("prereset_hit", {31'd0, rsp_hit}, 32'd1);
      check("prereset_target", rsp_target, 32'hABCD_2040);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("midreset_rsp_target", rsp_target, 32'd0);
      check("midreset_hit_cnt", hit_cnt, 32'd0);
      check("midreset_miss_cnt", miss_cnt, 32'd0);
      step();
      $display("in-reset cycle -> valid=%0b hit=%0b tgt=%h", rsp_valid, rsp_hit, rsp_target);
      check("inreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      lk_valid = 1'b0;
      rst_n = 1'b1;
      step();
      lk_valid = 1'b1;
      lk_pc    = 32'hABCD_1000;
      step();
      lk_valid = 1'b0;
      $display("post-reset lookup -> valid=%0b hit=%0b tgt=%h", rsp_valid, rsp_hit, rsp_target);
      check("postreset_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("postreset_rsp_hit", {31'd0, rsp_hit}, 32'd0);
      check("postreset_rsp_target", rsp_target, 32'hABCD_1004);
      step();
      check("postreset_miss_cnt", miss_cnt, 32'd1);
      check("postreset_hit_cnt", hit_cnt, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
